rr_arb8_4src: RTL
=================

Name: rr_arb8_4src

Overview:
- Round-robin arbiter that shares one 8-bit 4:1 mux datapath (mux8_4to1b) among four requesting sources.
- Owns the 2-bit select, issues one-hot grants and registers the selected byte onto a single output bus with a valid flag.
- Sits between four producers and one consumer.
- A hold limit prevents one source from starving the others.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles for one owner while another request is pending; legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; one clock, asynchronous and active-high.
- req  input  4  request per source; bit i = source i.
- A  input  8  source 0 data.
- B  input  8  source 1 data.
- C  input  8  source 2 data.
- D  input  8  source 3 data.
- grant  output  4  one-hot grant, registered; all-zero when idle.
- Sel  output  2  registered mux select; index of current or last owner.
- F  output  8  registered output byte.
- valid  output  1  F holds data sampled from the owner.

Behaviour:
- Reset (async, rst=1):
  - grant=0, Sel=0, F=0, valid=0.
  - State IDLE, priority pointer ptr=0, hold_cnt=0.
  - Outputs clear immediately on rst rise, mid-transfer included.
  - First arbitration happens on the first rising edge with rst=0.
- Pick function: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set req bit wins.
- State IDLE:
  - If req==0: stay; grant=0; Sel holds its last value.
  - If req!=0: at the edge, grant <= onehot(winner), Sel <= winner, hold_cnt <= 1, go to OWN.
  - Grant latency: one cycle after req is sampled.
- State OWN (owner o = Sel):
  - req[o]=0 (release):
    - ptr <= o+1.
    - If any other req: grant the pick from o+1 on the same edge; no idle bubble; hold_cnt <= 1.
    - Else: grant <= 0, go to IDLE.
  - req[o]=1, hold_cnt==MAX_HOLD, and another req pending (forced rotate): ptr <= o+1, grant the pick from o+1, hold_cnt <= 1.
  - req[o]=1, hold_cnt==MAX_HOLD, no other req: keep the grant; hold_cnt saturates at MAX_HOLD.
  - Otherwise: keep the grant; hold_cnt <= hold_cnt+1.
- Datapath:
  - Every edge: F <= mux8_4to1b output at the current Sel; valid <= |grant (grant and Sel as registered before the edge).
  - F and valid therefore trail grant by exactly one cycle.
  - When valid drops, F holds its last value.
- Simultaneous events: a new requester joining during an owner's tenure never preempts before MAX_HOLD.
- grant is always one-hot or zero, and always matches Sel when nonzero.
- hold_cnt width is 4 bits.

Decomposition:
- Shared package / include (lib.v style):
  - N_SRC=4, DATA_W=8.
  - State encodings ST_IDLE=1'b0, ST_OWN=1'b1.
  - HOLD_W=4.
- Natural sub-module rr_pick4: combinational (req[3:0], ptr[1:0]) -> (any, idx[1:0]).
- Data selection reuses the existing mux8_4to1b from lib.v, instantiated once.

Test Plan:
- Reset check: assert rst mid-run with req=4'b1111.
  - grant=0, Sel=0, F=0, valid=0 immediately, without waiting for a clock edge.
  - After release, the first grant is 4'b0001.
- Single requester: A=8'hAA, req=4'b0001, held 3 cycles, then dropped.
  - grant=0001 one cycle after req.
  - F=8'hAA with valid=1 one cycle later, for 3 cycles.
  - grant=0 and IDLE after the drop.
- Round-robin fairness: A=AA, B=55, C=F0, D=0F; req=4'b1111, each owner drops req after 2 cycles and re-raises it.
  - Grant order 0001, 0010, 0100, 1000, 0001.
  - F sequence AA, 55, F0, 0F.
  - No idle cycle between owners.
- Hold limit (MAX_HOLD=4): req[0] held continuously, req[2] asserted at cycle 1.
  - Source 0 is granted for exactly 4 cycles, then grant=0100, Sel=2, F=F0.
  - With req[0] still high, after 4 more cycles grant returns to 0001.
- Saturation: req=4'b0010 held 10 cycles.
  - grant=0010 remains throughout; no rotation; valid stays 1.
- Release with pointer wrap: owner 3 (req=1000) drops while req=0001 is pending.
  - grant=0001 on the same edge as the release, Sel=0.
  - ptr wraps 3→0 correctly.

Source files
------------

// File: rtl/rr_arb8_4src_pkg.sv
// Shared definitions for the 4-source round-robin byte arbiter.
// Provides source count, data and hold-counter widths, the FSM state type
// and a small one-hot helper used by the arbiter top.
package rr_arb8_4src_pkg;

   localparam int N_SRC  = 4;
   localparam int DATA_W = 8;
   localparam int HOLD_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   function automatic logic [N_SRC-1:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux8_4to1b.sv
// 8-bit 4:1 multiplexer shared by the four sources.
// Ports: i_a..i_d  data inputs (select 0..3)
//        i_sel     2-bit select
//        o_y       selected byte
module mux8_4to1b
   import rr_arb8_4src_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [DATA_W-1:0] i_c,
   input  logic [DATA_W-1:0] i_d,
   input  logic [1:0]        i_sel,
   output logic [DATA_W-1:0] o_y
);

   always_comb begin
      o_y = i_a;
      case (i_sel)
         2'd0:    o_y = i_a;
         2'd1:    o_y = i_b;
         2'd2:    o_y = i_c;
         default: o_y = i_d;
      endcase
   end

endmodule

// File: rtl/rr_arb8_4src_pick4.sv
// Rotating-priority picker: scans i_ptr, i_ptr+1, i_ptr+2, i_ptr+3 (mod 4)
// and reports the first set request.
// Ports: i_req  request vector
//        i_ptr  highest-priority index
//        o_any  at least one request set
//        o_idx  winning index (i_ptr when nothing is requested)
module rr_pick4
   import rr_arb8_4src_pkg::*;
(
   input  logic [N_SRC-1:0] i_req,
   input  logic [1:0]       i_ptr,
   output logic             o_any,
   output logic [1:0]       o_idx
);

   logic [1:0] w_scan;

   // Scan from the far end back toward i_ptr so the nearest hit wins.
   always_comb begin
      o_any  = |i_req;
      o_idx  = i_ptr;
      w_scan = i_ptr;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         w_scan = i_ptr + 2'(k);
         if (i_req[w_scan]) o_idx = w_scan;
      end
   end

endmodule

// File: rtl/rr_arb8_4src.sv
// Round-robin arbiter sharing one 8-bit 4:1 mux among four sources, with a
// hold limit so a continuously requesting owner cannot starve the others.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   ST_IDLE | no owner; grant=0, Sel keeps last owner
//   ST_OWN  | source Sel owns the mux; r_hold counts its tenure
//
// Ports: clk, rst (async, active-high)
//        req[3:0]   request per source
//        A,B,C,D    source 0..3 data
//        grant      registered one-hot grant, zero when idle
//        Sel        registered mux select (current or last owner)
//        F          registered output byte, trails grant by one cycle
//        valid      F holds data sampled from the owner
module rr_arb8_4src
   import rr_arb8_4src_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  req,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] C,
   input  logic [DATA_W-1:0] D,
   output logic [N_SRC-1:0]  grant,
   output logic [1:0]        Sel,
   output logic [DATA_W-1:0] F,
   output logic              valid
);

   state_t              r_state;
   logic [1:0]          r_ptr;
   logic [HOLD_W-1:0]   r_hold;
   logic [N_SRC-1:0]    r_grant;
   logic [1:0]          r_sel;
   logic [DATA_W-1:0]   r_f;
   logic                r_valid;

   logic [DATA_W-1:0]   w_mux;
   logic [1:0]          w_pick_ptr;
   logic                w_any;
   logic [1:0]          w_idx;
   logic                w_own_req;
   logic                w_others;
   logic                w_at_limit;

   // While owning, the next candidate is always searched from owner+1;
   // the owner's own bit is naturally scanned last.
   assign w_pick_ptr = (r_state == ST_OWN) ? r_sel + 2'd1 : r_ptr;
   assign w_own_req  = req[r_sel];
   assign w_others   = |(req & ~onehot4(r_sel));
   assign w_at_limit = (r_hold == HOLD_W'(MAX_HOLD));

   rr_pick4 u_pick (
      .i_req (req),
      .i_ptr (w_pick_ptr),
      .o_any (w_any),
      .o_idx (w_idx)
   );

   mux8_4to1b u_mux (
      .i_a   (A),
      .i_b   (B),
      .i_c   (C),
      .i_d   (D),
      .i_sel (r_sel),
      .o_y   (w_mux)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_hold  <= '0;
         r_grant <= '0;
         r_sel   <= '0;
         r_f     <= '0;
         r_valid <= 1'b0;
      end else begin
         // F only tracks the mux while someone owns it, so it holds after valid drops.
         if (|r_grant) r_f <= w_mux;
         r_valid <= |r_grant;

         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= onehot4(w_idx);
                  r_sel   <= w_idx;
                  r_hold  <= HOLD_W'(1);
                  r_state <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (!w_own_req) begin
                  r_ptr <= r_sel + 2'd1;
                  if (w_any) begin
                     r_grant <= onehot4(w_idx);
                     r_sel   <= w_idx;
                     r_hold  <= HOLD_W'(1);
                  end else begin
                     r_grant <= '0;
                     r_hold  <= '0;
                     r_state <= ST_IDLE;
                  end
               end else if (w_at_limit && w_others) begin
                  r_ptr   <= r_sel + 2'd1;
                  r_grant <= onehot4(w_idx);
                  r_sel   <= w_idx;
                  r_hold  <= HOLD_W'(1);
               end else if (!w_at_limit) begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign grant = r_grant;
   assign Sel   = r_sel;
   assign F     = r_f;
   assign valid = r_valid;

endmodule
